// File: rtl/mixer_mac_pkg.sv
// mixer_mac_pkg: shared definitions for the mixer_mac peripheral.
//   - register byte offsets and their addr[7:2] word indices
//   - CTRL / STATUS bit positions
//   - frame sequencer state encoding
//   - byte-strobe merge helper for bus writes
package mixer_mac_pkg;

    // Register byte offsets
    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_OUT       = 8'h08;
    localparam logic [7:0] OFF_GAIN_BASE = 8'h40;

    // Word indices as seen on addr[7:2]
    localparam logic [5:0] WORD_CTRL      = OFF_CTRL[7:2];
    localparam logic [5:0] WORD_STATUS    = OFF_STATUS[7:2];
    localparam logic [5:0] WORD_OUT       = OFF_OUT[7:2];
    localparam logic [5:0] WORD_GAIN_BASE = OFF_GAIN_BASE[7:2];

    // CTRL bits
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // STATUS bits
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_CLIP_BIT = 1;
    localparam int unsigned STAT_OVR_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Replace the bytes of old_val selected by strb with those of new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mixer_mac_if.sv
// mixer_mac_if: CPU bus connection for the mixer_mac peripheral.
//   valid  request, already address-qualified
//   ready  one-cycle acknowledge
//   wstrb  byte write strobes (0 = read)
//   addr   byte address, only [7:2] decoded by the slave
//   wdata  write data
//   rdata  read data, valid while ready=1, otherwise 0
interface mixer_mac_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mixer_mac_regs.sv
// mixer_mac_regs: bus slave and register file of the mixer.
//   clk, resetn   clock, asynchronous active-low reset
//   bus           CPU bus slave (ready pulse, byte-strobe writes, readback)
//   busy          frame in progress, shown in STATUS
//   out_val       current mixed sample, shown in OUT
//   clip_set      pulse: set CLIP sticky bit
//   ovr_set       pulse: set OVR sticky bit
//   gain          packed live gain vector, channel i at [i*GAIN_W +: GAIN_W]
//   enable        CTRL.enable
module mixer_mac_regs
    import mixer_mac_pkg::*;
#(
    parameter int unsigned CHANNELS = 5,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned OUT_W    = 12
) (
    input  logic                         clk,
    input  logic                         resetn,
    mixer_mac_if.slave                   bus,
    input  logic                         busy,
    input  logic [OUT_W-1:0]             out_val,
    input  logic                         clip_set,
    input  logic                         ovr_set,
    output logic [CHANNELS*GAIN_W-1:0]   gain,
    output logic                         enable
);

    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(1) << (GAIN_W - 1);

    logic                       ready_q, ready_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       en_q, en_d;
    logic                       clip_q, clip_d;
    logic                       ovr_q, ovr_d;
    logic [CHANNELS*GAIN_W-1:0] gain_q, gain_d;

    logic        access;
    logic [5:0]  word;
    logic [5:0]  gidx;
    logic        is_gain;
    logic        clr;
    logic [31:0] rd_val;

    // Only addr[7:2] is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    // Address decode; a request is accepted once, when first seen with ready low.
    always_comb begin
        access  = bus.valid && !ready_q;
        word    = bus.addr[7:2];
        gidx    = word - WORD_GAIN_BASE;
        is_gain = (word >= WORD_GAIN_BASE);
    end

    // Read mux; unmapped words and GAIN indices beyond CHANNELS read 0.
    always_comb begin
        rd_val = '0;
        case (word)
            WORD_CTRL: begin
                rd_val[CTRL_EN_BIT] = en_q;
            end
            WORD_STATUS: begin
                rd_val[STAT_BUSY_BIT] = busy;
                rd_val[STAT_CLIP_BIT] = clip_q;
                rd_val[STAT_OVR_BIT]  = ovr_q;
            end
            WORD_OUT: begin
                rd_val = 32'(out_val);
            end
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (is_gain && gidx == 6'(i)) begin
                        rd_val = 32'(gain_q[i*GAIN_W +: GAIN_W]);
                    end
                end
            end
        endcase
    end

    // Register updates; a new sticky event beats a simultaneous clear.
    always_comb begin
        ready_d = access;
        rdata_d = access ? rd_val : 32'h0;
        en_d    = en_q;
        gain_d  = gain_q;
        clr     = 1'b0;
        if (access && bus.wstrb != 4'b0000) begin
            if (word == WORD_CTRL && bus.wstrb[0]) begin
                en_d = bus.wdata[CTRL_EN_BIT];
                clr  = bus.wdata[CTRL_CLR_BIT];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (is_gain && gidx == 6'(i)) begin
                    gain_d[i*GAIN_W +: GAIN_W] = GAIN_W'(byte_merge(
                        32'(gain_q[i*GAIN_W +: GAIN_W]), bus.wdata, bus.wstrb));
                end
            end
        end
        clip_d = (clip_q && !clr) || clip_set;
        ovr_d  = (ovr_q && !clr) || ovr_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            en_q    <= 1'b1;
            clip_q  <= 1'b0;
            ovr_q   <= 1'b0;
            gain_q  <= {CHANNELS{GAIN_RST}};
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            clip_q  <= clip_d;
            ovr_q   <= ovr_d;
            gain_q  <= gain_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign gain      = gain_q;
    assign enable    = en_q;

endmodule

// File: rtl/mixer_mac.sv
// mixer_mac: N-channel audio mixer with per-channel gain, one shared multiplier.
//   clk, resetn  clock, asynchronous active-low reset
//   bus          CPU bus slave (CTRL, STATUS, OUT, GAIN[i])
//   sample       one-cycle sample strobe; starts a frame when idle and enabled
//   ch           packed channel samples, channel i at [i*IN_W +: IN_W]
//   out          mixed sample, held between frames
//   out_valid    one-cycle pulse when out updates
// Build option MIXER_MAC_CLIP_EN: when defined the result saturates and sets
// CLIP; otherwise it wraps to OUT_W bits and CLIP stays 0.
module mixer_mac
    import mixer_mac_pkg::*;
#(
    parameter int unsigned CHANNELS = 5,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned OUT_W    = 12
) (
    input  logic                       clk,
    input  logic                       resetn,
    mixer_mac_if.slave                 bus,
    input  logic                       sample,
    input  logic [CHANNELS*IN_W-1:0]   ch,
    output logic [OUT_W-1:0]           out,
    output logic                       out_valid
);

    localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PROD_W = IN_W + GAIN_W;
    localparam int unsigned ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS);

    state_e state_q, state_d;

    logic [CHANNELS*IN_W-1:0] snap_q, snap_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     out_valid_q, out_valid_d;

    logic [CHANNELS*GAIN_W-1:0] gain;
    logic                       enable;
    logic                       busy;
    logic                       clip_set;
    logic                       ovr_set;

    logic [IN_W-1:0]   snap_sel;
    logic [GAIN_W-1:0] gain_sel;
    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  res_val;
    logic              res_clip;

    mixer_mac_regs #(
        .CHANNELS (CHANNELS),
        .GAIN_W   (GAIN_W),
        .OUT_W    (OUT_W)
    ) u_regs (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .busy     (busy),
        .out_val  (out_q),
        .clip_set (clip_set),
        .ovr_set  (ovr_set),
        .gain     (gain),
        .enable   (enable)
    );

    assign busy = (state_q != IDLE);

    // Channel select for the shared multiplier; gain is read live.
    always_comb begin
        snap_sel = '0;
        gain_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                snap_sel = snap_q[i*IN_W +: IN_W];
                gain_sel = gain[i*GAIN_W +: GAIN_W];
            end
        end
        prod = PROD_W'(snap_sel) * PROD_W'(gain_sel);
    end

    // Scale back by unity gain and fit the result into OUT_W bits.
`ifdef MIXER_MAC_CLIP_EN
    localparam int unsigned WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    logic [WIDE_W-1:0] shifted;
    always_comb begin
        shifted  = WIDE_W'(acc_q) >> (GAIN_W - 1);
        res_clip = (shifted > WIDE_W'({OUT_W{1'b1}}));
        res_val  = res_clip ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end
`else
    always_comb begin
        res_val  = OUT_W'(acc_q >> (GAIN_W - 1));
        res_clip = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample && enable) state_d = ACC;
            ACC:     if (idx_q == IDX_W'(CHANNELS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        snap_d      = snap_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        clip_set    = 1'b0;
        ovr_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample && enable) begin
                    snap_d = ch;
                    acc_d  = '0;
                    idx_d  = '0;
                end
            end
            ACC: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
            end
            DONE: begin
                out_d       = res_val;
                out_valid_d = 1'b1;
                clip_set    = res_clip;
            end
            default: ;
        endcase
        // A strobe that arrives while a frame is in flight is dropped.
        if (sample && enable && state_q != IDLE) begin
            ovr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mixer_mac.sv
// tb_mixer_mac: self-checking bench for mixer_mac with a cycle-level
// behavioural model, directed literal checks and randomized traffic.
module tb_mixer_mac;

    localparam int unsigned C      = 5;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned GAIN_W = 8;
    localparam int unsigned OUT_W  = 10;
    localparam longint unsigned OUT_MAX = (64'd1 << OUT_W) - 1;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                sample = 1'b0;
    logic [C*IN_W-1:0]   ch = '0;
    logic [OUT_W-1:0]    out;
    logic                out_valid;

    mixer_mac_if bus();

    mixer_mac #(
        .CHANNELS (C),
        .IN_W     (IN_W),
        .GAIN_W   (GAIN_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .sample    (sample),
        .ch        (ch),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (state after the latest edge) -------
    int unsigned     m_gain [C];
    bit              m_en, m_clip, m_ovr, m_ready, m_ov;
    longint unsigned m_out;
    longint unsigned m_rdata;
    bit              f_on;      // a frame has been accepted and not yet output
    int              f_k;       // edges since the frame's sample edge
    int unsigned     f_snap [C];
    longint unsigned f_acc;

    task automatic model_reset();
        for (int i = 0; i < C; i++) m_gain[i] = 1 << (GAIN_W - 1);
        m_en = 1; m_clip = 0; m_ovr = 0; m_ready = 0; m_ov = 0;
        m_out = 0; m_rdata = 0; f_on = 0; f_k = 0; f_acc = 0;
    endtask

    function automatic longint unsigned merge32(input longint unsigned old_v,
                                                input logic [31:0] d, input logic [3:0] s);
        longint unsigned m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m |= 64'hFF << (8 * b);
        return (old_v & ~m & 64'hFFFF_FFFF) | (longint'(d) & m);
    endfunction

    function automatic longint unsigned model_read(input logic [31:0] a);
        int unsigned w = a[7:2];
        if (w == 0) return longint'(m_en);
        if (w == 1) return longint'(f_on) | (longint'(m_clip) << 1) | (longint'(m_ovr) << 2);
        if (w == 2) return m_out;
        if (w >= 16 && (w - 16) < C) return m_gain[w - 16];
        return 0;
    endfunction

    // Predict the state after the upcoming edge from the inputs now applied.
    task automatic model_advance();
        bit busy = f_on;
        bit en   = m_en;
        bit clr = 0, cset = 0, oset = 0;
        bit n_ready;
        longint unsigned n_rdata = 0;
        longint unsigned sh;
        int unsigned w = bus.addr[7:2];
        n_ready = bus.valid && !m_ready;
        if (n_ready) n_rdata = model_read(bus.addr);
        m_ov = 0;
        if (f_on) begin
            f_k++;
            if (f_k <= C) begin
                f_acc += longint'(f_snap[f_k-1]) * longint'(m_gain[f_k-1]);
            end else begin
                sh = f_acc >> (GAIN_W - 1);
`ifdef MIXER_MAC_CLIP_EN
                if (sh > OUT_MAX) begin m_out = OUT_MAX; cset = 1; end
                else m_out = sh;
`else
                m_out = sh & OUT_MAX;
`endif
                m_ov = 1;
                f_on = 0;
            end
        end
        if (sample && en) begin
            if (busy) oset = 1;
            else begin
                f_on = 1; f_k = 0; f_acc = 0;
                for (int i = 0; i < C; i++) f_snap[i] = ch[i*IN_W +: IN_W];
            end
        end
        if (n_ready && bus.wstrb != 4'b0000) begin
            if (w == 0 && bus.wstrb[0]) begin
                m_en = bus.wdata[0];
                clr  = bus.wdata[1];
            end
            if (w >= 16 && (w - 16) < C)
                m_gain[w-16] = int'(merge32(m_gain[w-16], bus.wdata, bus.wstrb)
                                    & ((64'd1 << GAIN_W) - 1));
        end
        if (clr) begin m_clip = 0; m_ovr = 0; end
        if (cset) m_clip = 1;
        if (oset) m_ovr = 1;
        m_ready = n_ready;
        m_rdata = n_rdata;
    endtask

    // Compare outputs against the model mid-cycle, then step the model.
    always @(negedge clk) begin
        if (!resetn) model_reset();
        check("ready",     longint'(bus.ready), longint'(m_ready));
        check("rdata",     longint'(bus.rdata), longint'(m_rdata));
        check("out",       longint'(out),       longint'(m_out));
        check("out_valid", longint'(out_valid), longint'(m_ov));
        if (resetn) model_advance();
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r);
        logic rdy1;
        bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
        tick();
        rdy1 = bus.ready;
        r    = bus.rdata;
        bus.valid = 1'b0; bus.wstrb = 4'b0000;
        tick();
        check("ready_one_cycle", longint'({rdy1, bus.ready}), 64'd2);
    endtask

    task automatic pulse_sample();
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic set_ch5(input int a, input int b, input int c, input int d, input int e);
        ch[0*IN_W +: IN_W] = IN_W'(a);
        ch[1*IN_W +: IN_W] = IN_W'(b);
        ch[2*IN_W +: IN_W] = IN_W'(c);
        ch[3*IN_W +: IN_W] = IN_W'(d);
        ch[4*IN_W +: IN_W] = IN_W'(e);
    endtask

    task automatic set_all_gains(input logic [31:0] g);
        logic [31:0] r;
        for (int i = 0; i < C; i++) bus_xfer(32'h40 + 32'(4 * i), g, 4'b0001, r);
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        int          extra;
        int          hold;
        logic [31:0] rnd;
        logic [5:0]  w;

        bus.valid = 1'b0; bus.wstrb = 4'b0000; bus.addr = '0; bus.wdata = '0;
        resetn = 1'b0;
        repeat (3) tick();
        check("rst_out",       longint'(out),       0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_ready",     longint'(bus.ready), 0);
        check("rst_rdata",     longint'(bus.rdata), 0);
        resetn = 1'b1;
        tick();
        bus_xfer(32'h0, 32'h0, 4'b0000, r);  check("ctrl_reset", longint'(r), 1);
        bus_xfer(32'h40, 32'h0, 4'b0000, r); check("gain0_reset", longint'(r), 128);

        // Unity mix
        set_ch5(10, 20, 30, 40, 50);
        pulse_sample();
        wait_ov(n);
        check("unity_latency", n, 6);
        check("unity_out", longint'(out), 150);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("unity_status", longint'(r), 0);

        // Byte-strobed gain write
        bus_xfer(32'h48, 32'hFFFF_FF40, 4'b0001, r);
        bus_xfer(32'h48, 32'h0000_0011, 4'b0010, r);
        set_ch5(100, 100, 100, 100, 100);
        pulse_sample();
        wait_ov(n);
        check("gain_out", longint'(out), 450);
        bus_xfer(32'h48, 32'h0, 4'b0000, r); check("gain_readback", longint'(r), 64'h40);
        bus_xfer(32'h5C, 32'h0, 4'b0000, r); check("gain_oob_read", longint'(r), 0);

        // Full-scale: saturation or wrap depending on build
        set_all_gains(32'hFF);
        set_ch5(255, 255, 255, 255, 255);
        pulse_sample();
        wait_ov(n);
`ifdef MIXER_MAC_CLIP_EN
        check("full_out", longint'(out), 1023);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("clip_status", longint'(r), 2);
`else
        check("full_out", longint'(out), 492);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("clip_status", longint'(r), 0);
`endif
        bus_xfer(32'h0, 32'h3, 4'b0001, r);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("clip_cleared", longint'(r), 0);
        bus_xfer(32'h0, 32'h0, 4'b0000, r); check("ctrl_after_clr", longint'(r), 1);
        set_all_gains(32'h80);

        // Overrun: second strobe three cycles in is dropped
        set_ch5(1, 2, 3, 4, 5);
        pulse_sample();
        set_ch5(200, 200, 200, 200, 200);
        tick(); tick();
        pulse_sample();
        wait_ov(n);
        check("ovr_latency", n, 3);
        check("ovr_out", longint'(out), 15);
        extra = 0;
        repeat (10) begin tick(); if (out_valid) extra++; end
        check("ovr_single_pulse", extra, 0);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("ovr_status", longint'(r), 4);
        bus_xfer(32'h0, 32'h3, 4'b0001, r);

        // Reset in the middle of a frame
        set_ch5(7, 7, 7, 7, 7);
        pulse_sample();
        tick(); tick(); tick();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        check("midrst_out", longint'(out), 0);
        extra = 0;
        repeat (C + 4) begin tick(); if (out_valid) extra++; end
        check("midrst_no_pulse", extra, 0);
        bus_xfer(32'h4, 32'h0, 4'b0000, r); check("midrst_busy", longint'(r), 0);
        set_ch5(10, 20, 30, 40, 50);
        pulse_sample();
        wait_ov(n);
        check("midrst_next_latency", n, 6);
        check("midrst_next_out", longint'(out), 150);

        // Randomized traffic; the model checks every cycle
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < C; i++) ch[i*IN_W +: IN_W] = IN_W'($urandom);
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    rnd = $urandom;
                    case ($urandom_range(0, 7))
                        0:       w = 6'd0;
                        1:       w = 6'd1;
                        2:       w = 6'd2;
                        3:       w = 6'(3 + $urandom_range(0, 12));
                        4:       w = 6'(16 + $urandom_range(0, 7));
                        5:       w = 6'd63;
                        default: w = 6'(16 + $urandom_range(0, C - 1));
                    endcase
                    bus.valid = 1'b1;
                    bus.addr  = {rnd[31:8], w, rnd[1:0]};
                    bus.wstrb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                    bus.wdata = $urandom;
                    if (w == 6'd0) bus.wdata[0] = ($urandom_range(0, 7) != 0);
                    hold = $urandom_range(1, 3);
                end else begin
                    bus.valid = 1'b0;
                    bus.wstrb = 4'b0000;
                end
            end
            tick();
            if (hold > 0) hold--;
        end
        bus.valid = 1'b0;
        bus.wstrb = 4'b0000;
        sample    = 1'b0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
